// File: rtl/i2s_frame_tx.sv
// I2S transmitter for the microphone array output: one-deep sample hold buffer,
// slot framing from an external word select, MSB-first serialization.
module i2s_frame_tx #(
  parameter int IN_W   = 8,
  parameter int SLOT_W = 16,
  parameter int MONO   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lr_clk,
  input  logic [IN_W-1:0] sample_in,
  input  logic            sample_valid,
  input  logic            clear_flags,
  output logic            i2s_sd,
  output logic            frame_start,
  output logic            overflow,
  output logic            underflow
);

  localparam int PAD_W = SLOT_W - IN_W;

  logic              lr_q;
  logic [IN_W-1:0]   hold_reg;
  logic              hold_full_reg;
  logic              primed_reg;
  logic [IN_W-1:0]   frame_word_reg;
  logic [SLOT_W-1:0] shift_reg;

  logic              slot_edge;
  logic              left_edge;
  logic              right_edge;
  logic              consume;
  logic              ovf_set;
  logic              udf_set;
  logic [IN_W-1:0]   frame_word_next;
  logic [SLOT_W-1:0] slot_word;

  // MSB-justify the sample in the slot; the LSBs are zero, not sign bits.
  function automatic logic [SLOT_W-1:0] pad_word(input logic [IN_W-1:0] w);
    return SLOT_W'(w) << PAD_W;
  endfunction

  always_comb begin
    slot_edge  = (lr_clk != lr_q);
    left_edge  = slot_edge & ~lr_clk;
    right_edge = slot_edge & lr_clk;
    consume    = left_edge & hold_full_reg;

    frame_word_next = frame_word_reg;
    if (left_edge) begin
      frame_word_next = hold_full_reg ? hold_reg : '0;
    end

    // A sample landing on the consuming edge refills the buffer, so it is not an overwrite.
    ovf_set = sample_valid & hold_full_reg & ~consume;
    udf_set = left_edge & ~hold_full_reg & primed_reg;

    slot_word = '0;
    if (left_edge) begin
      slot_word = pad_word(frame_word_next);
    end else if (right_edge && (MONO != 0)) begin
      slot_word = pad_word(frame_word_reg);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lr_q <= 1'b0;
    end else begin
      lr_q <= lr_clk;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_reg       <= '0;
      hold_full_reg  <= 1'b0;
      primed_reg     <= 1'b0;
      frame_word_reg <= '0;
    end else begin
      if (sample_valid) begin
        hold_reg      <= sample_in;
        hold_full_reg <= 1'b1;
        primed_reg    <= 1'b1;
      end else if (consume) begin
        hold_full_reg <= 1'b0;
      end
      frame_word_reg <= frame_word_next;
    end
  end

  // Once the slot bits are exhausted the register has shifted in zeros, so the line idles low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg   <= '0;
      i2s_sd      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (slot_edge) begin
        i2s_sd    <= slot_word[SLOT_W-1];
        shift_reg <= slot_word << 1;
      end else begin
        i2s_sd    <= shift_reg[SLOT_W-1];
        shift_reg <= shift_reg << 1;
      end
      frame_start <= left_edge;
    end
  end

  // Setting wins over a simultaneous clear so no event is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (clear_flags) begin
        overflow <= 1'b0;
      end
      if (udf_set) begin
        underflow <= 1'b1;
      end else if (clear_flags) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_frame_tx.sv
// Directed bench for i2s_frame_tx: a MONO=1 and a MONO=0 instance share all inputs.
module tb_i2s_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       lr_clk;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       clear_flags;
  logic       sd_m, fs_m, ov_m, uf_m;
  logic       sd_s, fs_s, ov_s, uf_s;

  int checks   = 0;
  int failures = 0;

  logic [15:0] bm, bs;
  int          fsc;
  logic        tail;

  always #5 clk = ~clk;

  i2s_frame_tx #(.IN_W(8), .SLOT_W(16), .MONO(1)) dut_m (
    .clk(clk), .rst(rst), .lr_clk(lr_clk), .sample_in(sample_in),
    .sample_valid(sample_valid), .clear_flags(clear_flags),
    .i2s_sd(sd_m), .frame_start(fs_m), .overflow(ov_m), .underflow(uf_m)
  );

  i2s_frame_tx #(.IN_W(8), .SLOT_W(16), .MONO(0)) dut_s (
    .clk(clk), .rst(rst), .lr_clk(lr_clk), .sample_in(sample_in),
    .sample_valid(sample_valid), .clear_flags(clear_flags),
    .i2s_sd(sd_s), .frame_start(fs_s), .overflow(ov_s), .underflow(uf_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one slot of len cycles starting with the lr_clk change; n=0 is the edge cycle.
  task automatic slot(input logic lr, input int len,
                      input int v1_cyc, input logic [7:0] v1_dat,
                      input int v2_cyc, input logic [7:0] v2_dat,
                      input int clr_cyc,
                      output logic [15:0] m_bits, output logic [15:0] s_bits,
                      output int fs_cnt, output logic tail_hi);
    m_bits  = '0;
    s_bits  = '0;
    fs_cnt  = 0;
    tail_hi = 1'b0;
    lr_clk  = lr;
    for (int n = 0; n < len; n++) begin
      sample_valid = (n == v1_cyc) || (n == v2_cyc);
      sample_in    = (n == v1_cyc) ? v1_dat : ((n == v2_cyc) ? v2_dat : 8'h00);
      clear_flags  = (n == clr_cyc);
      cyc();
      sample_valid = 1'b0;
      sample_in    = 8'h00;
      clear_flags  = 1'b0;
      if (n < 16) begin
        m_bits[15-n] = sd_m;
        s_bits[15-n] = sd_s;
      end else if (sd_m || sd_s) begin
        tail_hi = 1'b1;
      end
      fs_cnt += int'(fs_m);
    end
  endtask

  initial begin
    rst          = 1'b1;
    lr_clk       = 1'b0;
    sample_in    = 8'h00;
    sample_valid = 1'b0;
    clear_flags  = 1'b0;
    repeat (3) cyc();
    chk("rst_sd", {31'd0, sd_m}, 32'd0);
    chk("rst_fs", {31'd0, fs_m}, 32'd0);
    chk("rst_ov", {31'd0, ov_m}, 32'd0);
    chk("rst_uf", {31'd0, uf_m}, 32'd0);
    rst = 1'b0;
    repeat (3) cyc();

    // No sample ever sent: slots are zero and no underflow
    slot(1'b1, 32, -1, 8'h00, -1, 8'h00, -1, bm, bs, fsc, tail);
    chk("init_right", {16'd0, bm}, 32'h0000);
    slot(1'b0, 32, -1, 8'h00, -1, 8'h00, -1, bm, bs, fsc, tail);
    chk("init_left", {16'd0, bm}, 32'h0000);
    chk("init_fs", fsc, 32'd1);
    chk("init_no_uf", {31'd0, uf_m}, 32'd0);

    // Basic left/right with 0xA5
    slot(1'b1, 32, 5, 8'hA5, -1, 8'h00, -1, bm, bs, fsc, tail);
    chk("basic_pre_right", {16'd0, bm}, 32'h0000);
    chk("basic_right_fs", fsc, 32'd0);
    slot(1'b0, 32, -1, 8'h00, -1, 8'h00, -1, bm, bs, fsc, tail);
    chk("basic_left_mono", {16'd0, bm}, 32'hA500);
    chk("basic_left_stereo", {16'd0, bs}, 32'hA500);
    chk("basic_left_fs", fsc, 32'd1);
    chk("basic_tail_zero", {31'd0, tail}, 32'd0);
    slot(1'b1, 32, -1, 8'h00, -1, 8'h00, -1, bm, bs, fsc, tail);
    chk("basic_right_mono", {16'd0, bm}, 32'hA500);
    chk("basic_right_stereo", {16'd0, bs}, 32'h0000);
    chk("basic_ov", {31'd0, ov_m}, 32'd0);
    chk("basic_uf", {31'd0, uf_m}, 32'd0);

    // Overflow: newest sample wins
    slot(1'b1, 32, 3, 8'h11, 10, 8'h22, -1, bm, bs, fsc, tail);
    chk("ovf_set", {31'd0, ov_m}, 32'd1);
    chk("ovf_set_stereo", {31'd0, ov_s}, 32'd1);
    slot(1'b0, 32, -1, 8'h00, -1, 8'h00, -1, bm, bs, fsc, tail);
    chk("ovf_left_word", {16'd0, bm}, 32'h2200);
    clear_flags = 1'b1;
    cyc();
    clear_flags = 1'b0;
    chk("ovf_cleared", {31'd0, ov_m}, 32'd0);
    slot(1'b1, 32, 2, 8'h33, 6, 8'h44, 6, bm, bs, fsc, tail);
    chk("ovf_set_beats_clear", {31'd0, ov_m}, 32'd1);
    slot(1'b0, 32, -1, 8'h00, -1, 8'h00, -1, bm, bs, fsc, tail);
    chk("ovf2_left_word", {16'd0, bm}, 32'h4400);

    // Underflow after starving one frame
    slot(1'b1, 32, -1, 8'h00, -1, 8'h00, -1, bm, bs, fsc, tail);
    chk("udf_pre_right", {16'd0, bm}, 32'h4400);
    slot(1'b0, 32, -1, 8'h00, -1, 8'h00, -1, bm, bs, fsc, tail);
    chk("udf_left_word", {16'd0, bm}, 32'h0000);
    chk("udf_set", {31'd0, uf_m}, 32'd1);
    clear_flags = 1'b1;
    cyc();
    clear_flags = 1'b0;
    chk("udf_cleared", {31'd0, uf_m}, 32'd0);
    chk("ovf_cleared2", {31'd0, ov_m}, 32'd0);

    // Valid coinciding with the left edge while hold is full
    slot(1'b1, 32, 4, 8'h80, -1, 8'h00, -1, bm, bs, fsc, tail);
    slot(1'b0, 32, 0, 8'h7F, -1, 8'h00, -1, bm, bs, fsc, tail);
    chk("coin_left_word", {16'd0, bm}, 32'h8000);
    chk("coin_no_ov", {31'd0, ov_m}, 32'd0);
    slot(1'b1, 32, -1, 8'h00, -1, 8'h00, -1, bm, bs, fsc, tail);
    chk("coin_right_word", {16'd0, bm}, 32'h8000);
    slot(1'b0, 32, -1, 8'h00, -1, 8'h00, -1, bm, bs, fsc, tail);
    chk("coin_next_left", {16'd0, bm}, 32'h7F00);
    chk("coin_no_uf", {31'd0, uf_m}, 32'd0);

    // Short slots of 10 bits
    slot(1'b1, 10, 2, 8'hA5, -1, 8'h00, -1, bm, bs, fsc, tail);
    chk("short_right_prev", {16'd0, bm}, 32'h7F00);
    slot(1'b0, 10, -1, 8'h00, -1, 8'h00, -1, bm, bs, fsc, tail);
    chk("short_left", {16'd0, bm}, 32'hA500);
    chk("short_left_fs", fsc, 32'd1);
    slot(1'b1, 10, 1, 8'h99, 4, 8'h5A, -1, bm, bs, fsc, tail);
    chk("short_right_reload", {16'd0, bm}, 32'hA500);
    chk("short_ov", {31'd0, ov_m}, 32'd1);
    slot(1'b0, 2, -1, 8'h00, -1, 8'h00, -1, bm, bs, fsc, tail);
    chk("mid_slot_bits", {30'd0, bm[15:14]}, 32'd1);
    chk("mid_slot_sd", {31'd0, sd_m}, 32'd1);

    // Asynchronous reset mid-slot
    #2;
    rst = 1'b1;
    #1;
    chk("arst_sd", {31'd0, sd_m}, 32'd0);
    chk("arst_sd_stereo", {31'd0, sd_s}, 32'd0);
    chk("arst_ov", {31'd0, ov_m}, 32'd0);
    chk("arst_fs", {31'd0, fs_m}, 32'd0);
    repeat (2) cyc();
    rst = 1'b0;
    fsc = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      fsc += int'(fs_m);
    end
    chk("post_rst_no_fs", fsc, 32'd0);
    slot(1'b1, 16, -1, 8'h00, -1, 8'h00, -1, bm, bs, fsc, tail);
    chk("post_rst_right", {16'd0, bm}, 32'h0000);
    slot(1'b0, 16, -1, 8'h00, -1, 8'h00, -1, bm, bs, fsc, tail);
    chk("post_rst_left", {16'd0, bm}, 32'h0000);
    chk("post_rst_no_uf", {31'd0, uf_m}, 32'd0);
    slot(1'b1, 16, 3, 8'hC3, -1, 8'h00, -1, bm, bs, fsc, tail);
    slot(1'b0, 16, -1, 8'h00, -1, 8'h00, -1, bm, bs, fsc, tail);
    chk("post_rst_sample", {16'd0, bm}, 32'hC300);
    chk("post_rst_fs", fsc, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
